// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline hazard controller ID-stage interface: decode fields in, pipeline controls and status out.
// Latency: n/a (wires only).
// Backpressure: n/a; stall and flush are expressed by pc_en/if_id_en/if_id_flush/id_ex_bubble.
//
// Ports (master = pipeline/ID stage, slave = hazard controller):
//   id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_branch_taken : ID instruction fields
//   sb_hold       : test hook, freezes the destination-register scoreboard while high
//   pc_en, if_id_en, if_id_flush, id_ex_bubble, hazard : pipeline controls
//   stall_count, flush_count, stall_timeout             : performance counters and sticky error
interface pipeline_hazard_controller_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 id_valid;
  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [4:0]           id_rd;
  logic                 id_reg_write;
  logic                 id_branch_taken;
  logic                 sb_hold;
  logic                 pc_en;
  logic                 if_id_en;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic                 hazard;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;
  logic                 stall_timeout;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_branch_taken, sb_hold,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, hazard, stall_count, flush_count, stall_timeout
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_reg_write, id_branch_taken, sb_hold,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, hazard, stall_count, flush_count, stall_timeout
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for a 5-stage RV32 pipeline without forwarding (RAW scoreboard over EX/MW/WB).
// Latency: controls are combinational (zero-cycle); scoreboard, counters and timeout update on the next clk edge.
// Backpressure: on a RAW hazard PC and IF_ID freeze and ID_EX takes a bubble; a taken branch flushes IF_ID.
//
// Ports: clk, resetn (async active-low), hc (slave modport of pipeline_hazard_controller_if).
module pipeline_hazard_controller #(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  pipeline_hazard_controller_if.slave   hc
);

  // Longest legal run of consecutive hazard cycles; one more means the scoreboard is stuck.
  localparam logic [2:0]           LIMIT   = WB_BYPASS ? 3'd2 : 3'd3;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 r_ex_v, r_mw_v, r_wb_v;
  logic [4:0]           r_ex_rd, r_mw_rd, r_wb_rd;
  logic [CNT_WIDTH-1:0] r_stall_count, r_flush_count;
  logic [2:0]           r_hz_cnt;
  logic                 r_stall_timeout;

  logic w_match_rs1, w_match_rs2, w_raw, w_issue;
  logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_bubble, w_hazard;

  function automatic logic f_match(
    input logic [4:0] r,
    input logic ex_v, input logic [4:0] ex_rd,
    input logic mw_v, input logic [4:0] mw_rd,
    input logic wb_v, input logic [4:0] wb_rd
  );
    return (r != 5'd0) &&
           ((ex_v && ex_rd == r) || (mw_v && mw_rd == r) || (!WB_BYPASS && wb_v && wb_rd == r));
  endfunction

  assign w_match_rs1 = f_match(hc.id_rs1, r_ex_v, r_ex_rd, r_mw_v, r_mw_rd, r_wb_v, r_wb_rd);
  assign w_match_rs2 = f_match(hc.id_rs2, r_ex_v, r_ex_rd, r_mw_v, r_mw_rd, r_wb_v, r_wb_rd);
  assign w_raw   = hc.id_valid && ((hc.id_use_rs1 && w_match_rs1) || (hc.id_use_rs2 && w_match_rs2));
  assign w_issue = hc.id_valid && !w_raw;

  // Reset forces the frozen/bubble pattern; hazard beats branch because the
  // branch comparator saw stale operands.
  always_comb begin
    w_pc_en        = 1'b0;
    w_if_id_en     = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b1;
    w_hazard       = 1'b0;
    if (resetn) begin
      w_hazard = w_raw;
      if (!w_raw) begin
        w_pc_en    = 1'b1;
        w_if_id_en = 1'b1;
        if (hc.id_valid && hc.id_branch_taken) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b0;
        end else begin
          w_id_ex_bubble = !hc.id_valid;
        end
      end
    end
  end

  // Scoreboard shift; x0 writes are dropped so they never match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex_v  <= 1'b0;
      r_mw_v  <= 1'b0;
      r_wb_v  <= 1'b0;
      r_ex_rd <= 5'd0;
      r_mw_rd <= 5'd0;
      r_wb_rd <= 5'd0;
    end else if (!hc.sb_hold) begin
      r_wb_v  <= r_mw_v;
      r_wb_rd <= r_mw_rd;
      r_mw_v  <= r_ex_v;
      r_mw_rd <= r_ex_rd;
      r_ex_v  <= w_issue && hc.id_reg_write && (hc.id_rd != 5'd0);
      r_ex_rd <= hc.id_rd;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_hazard && r_stall_count != '1)
        r_stall_count <= r_stall_count + CNT_ONE;
      if (w_if_id_flush && r_flush_count != '1)
        r_flush_count <= r_flush_count + CNT_ONE;
    end
  end

  // Consecutive-hazard watchdog: trips on the hazard cycle that would push
  // the run length past LIMIT; the run counter saturates at 7.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hz_cnt        <= 3'd0;
      r_stall_timeout <= 1'b0;
    end else if (w_hazard) begin
      if (r_hz_cnt >= LIMIT)
        r_stall_timeout <= 1'b1;
      if (r_hz_cnt != 3'd7)
        r_hz_cnt <= r_hz_cnt + 3'd1;
    end else begin
      r_hz_cnt <= 3'd0;
    end
  end

  assign hc.pc_en         = w_pc_en;
  assign hc.if_id_en      = w_if_id_en;
  assign hc.if_id_flush   = w_if_id_flush;
  assign hc.id_ex_bubble  = w_id_ex_bubble;
  assign hc.hazard        = w_hazard;
  assign hc.stall_count   = r_stall_count;
  assign hc.flush_count   = r_flush_count;
  assign hc.stall_timeout = r_stall_timeout;

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Stall/flush sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MW, WB). It keeps a 3-entry destination-register scoreboard for the EX, MW and WB stages, detects read-after-write hazards against the instruction in ID, and inserts bubbles by freezing PC and IF_ID while zeroing ID_EX controls. It flushes IF_ID when ID resolves a taken branch, and keeps saturating stall/flush performance counters plus a sticky stall-timeout error flag. The pipeline has no forwarding, so this block alone guarantees correct register operands.

## Interface

Parameters:
- WB_BYPASS, 0, 1 = register file writes before reading in the same cycle, so the WB stage is not a hazard source.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- id_valid  in  1  IF_ID holds a real instruction.
- id_rs1  in  5  rs1 address of the ID instruction.
- id_rs2  in  5  rs2 address of the ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  5  rd address of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_branch_taken  in  1  branch comparator result for the ID instruction.
- pc_en  out  1  PC loads pc_next.
- if_id_en  out  1  IF_ID captures a new instruction.
- if_id_flush  out  1  IF_ID loads a NOP (id_valid=0) next edge.
- id_ex_bubble  out  1  ID_EX loads all-zero controls (reg_write=0, data_mem_write=0).
- hazard  out  1  RAW hazard detected this cycle.
- stall_count  out  CNT_WIDTH  hazard cycles since reset, saturating.
- flush_count  out  CNT_WIDTH  flush cycles since reset, saturating.
- stall_timeout  out  1  sticky error flag; cleared only by reset.

## Operation

- Scoreboard: entries ex, mw and wb, each holding {v, rd}. Every edge: wb<=mw, mw<=ex, ex<={issue & id_reg_write & (id_rd!=0), id_rd}.
- issue = id_valid & !hazard. A bubble enters ex with v=0.
- match(r) = (r!=0) & ((ex.v & ex.rd==r) | (mw.v & mw.rd==r) | (!WB_BYPASS & wb.v & wb.rd==r)).
- hazard = id_valid & ((id_use_rs1 & match(id_rs1)) | (id_use_rs2 & match(id_rs2))). Register x0 never causes a hazard.
- On hazard: pc_en=0, if_id_en=0, id_ex_bubble=1, if_id_flush=0. id_branch_taken is ignored because its operands are stale.
- No hazard, id_valid=1 and id_branch_taken=1: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_bubble=0. The branch instruction itself issues.
- Otherwise: pc_en=1, if_id_en=1, if_id_flush=0. id_ex_bubble is set to !id_valid.
- Priority: reset > hazard > branch flush > normal.
- Counters: stall_count increments when hazard=1; flush_count increments when if_id_flush=1. Both hold at all-ones.
- Timeout: a 3-bit consecutive-hazard counter clears on any non-hazard cycle. stall_timeout sets when the counter would exceed LIMIT (3 if WB_BYPASS=0, else 2), which cannot occur in a legal pipeline. The counter saturates at 7.

## Timing

- Outputs pc_en, if_id_en, if_id_flush, id_ex_bubble and hazard are combinational from the ID inputs and the scoreboard registers. Zero-cycle decision.
- Scoreboard, counters and timeout update on the rising clk edge following the decision.
- Dependent back-to-back pair (producer at cycle 0): the consumer stalls at cycles 1, 2 and 3 (WB_BYPASS=0) or at cycles 1 and 2 (WB_BYPASS=1), then issues.
- Dependency at distance 2: one fewer stall. At distance 4 or more (3 or more with bypass): no stall.
- A taken branch costs 1 flush cycle. The fetched wrong-path instruction arrives in ID with id_valid=0.
- Reset (asynchronous assert, any cycle, including mid-stall):
  - scoreboard v bits clear, counters clear, stall_timeout=0;
  - while resetn=0: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=1, hazard=0.
- Reset release: normal operation from the first edge. There is no residual stall.

## Test plan

- `addi x1,x0,5` then `add x2,x1,x1`, WB_BYPASS=0 -> hazard=1 for exactly 3 cycles, then the add issues; stall_count=3, stall_timeout=0.
- Same pair with WB_BYPASS=1 -> 2 stall cycles, stall_count=2.
- Producer writes x0, then a consumer reads x0 -> no stall; stall_count=0.
- Taken `beq` with no hazard -> if_id_flush=1 for 1 cycle and flush_count=1. Taken `beq` whose rs1 is pending in EX -> flush stays 0 until the hazard clears, then 1 cycle of flush.
- Force id_valid=1 with a matching rs1 and hold the scoreboard entries by test hook -> stall_timeout sets on the 4th consecutive hazard cycle and stays 1 until resetn=0.
- Assert resetn=0 during the second stall cycle -> all outputs take reset values immediately; after release the consumer issues without a stall.
